// File: rtl/spi_frame_sequencer.sv
// spi_frame_sequencer: walks a constant word table, framing words under an
// active-low sync and handing each word to a byte-wide SPI master with a
// one-cycle start pulse. Power-up delay, optional looping, trigger and abort.
module spi_frame_sequencer #(
  parameter int                          DATA_W    = 8,
  parameter int                          NUM_WORDS = 7,
  parameter logic [NUM_WORDS*DATA_W-1:0] INIT_DATA = '0,
  parameter logic [NUM_WORDS-1:0]        FRAME_END = '0,
  parameter int                          PWR_WAIT  = 1000,
  parameter int                          GAP_CYC   = 2,
  parameter bit                          LOOP      = 1'b0,
  localparam int                         IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic              abort,
  input  logic              spi_done,
  output logic              start,
  output logic [DATA_W-1:0] data_out,
  output logic              sync,
  output logic [IDX_W-1:0]  word_idx,
  output logic              seq_done
);

  localparam int MAX_CNT = (PWR_WAIT > GAP_CYC) ? PWR_WAIT : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_WAIT);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_WAIT_PWR, S_CS_SETUP, S_START, S_XFER, S_GAP, S_DONE
  } state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [IDX_W-1:0]    idx_nx;
  logic                frame_end;
  logic                active_nx;
  logic [DATA_W-1:0]   table_w [NUM_WORDS];

  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_tbl
    assign table_w[i] = INIT_DATA[i*DATA_W +: DATA_W];
  end

  // data_out follows the registered index only, so it cannot glitch mid-word
  assign data_out  = table_w[word_idx];
  // the final table word always closes a frame
  assign frame_end = FRAME_END[word_idx] | (word_idx == LAST_IDX);

  // Next-state, next-index and counter decode
  always_comb begin
    state_nx = state;
    idx_nx   = word_idx;
    unique case (state)
      // cnt holds the number of edges already spent here, so sync falls
      // on edge PWR_WAIT (edge 0 when PWR_WAIT is 0)
      S_WAIT_PWR: if (cnt == PWR_LAST) state_nx = S_CS_SETUP;
      S_CS_SETUP: state_nx = S_START;
      S_START:    state_nx = S_XFER;
      S_XFER: if (spi_done) begin
        idx_nx   = (word_idx == LAST_IDX) ? '0 : word_idx + 1'b1;
        state_nx = frame_end ? S_GAP : S_START;
      end
      // index back at 0 means the word just sent was the last table entry
      S_GAP: if (cnt == GAP_LAST)
        state_nx = ((word_idx != '0) || LOOP) ? S_CS_SETUP : S_DONE;
      S_DONE: if (trig) begin
        state_nx = S_CS_SETUP;
        idx_nx   = '0;
      end
      default: state_nx = S_WAIT_PWR;
    endcase
    // abort wins over a coincident spi_done
    if (abort && (state inside {S_CS_SETUP, S_START, S_XFER, S_GAP})) begin
      state_nx = S_DONE;
      idx_nx   = '0;
    end
    // counter restarts on every state entry and only runs in timed states
    if (state_nx != state)                           cnt_nx = '0;
    else if ((state == S_WAIT_PWR) || (state == S_GAP)) cnt_nx = cnt + 1'b1;
    else                                             cnt_nx = '0;
    active_nx = state_nx inside {S_CS_SETUP, S_START, S_XFER};
  end

  // State, counter, index and registered output decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_WAIT_PWR;
      cnt      <= '0;
      word_idx <= '0;
      sync     <= 1'b1;
      start    <= 1'b0;
      seq_done <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      word_idx <= idx_nx;
      sync     <= !active_nx;
      start    <= (state_nx == S_START);
      seq_done <= (state_nx == S_DONE);
    end
  end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Directed bench for spi_frame_sequencer: three instances (one-shot 7-word
// table, looping 7-word table, single-word zero-delay) each served by a
// simple SPI responder that returns spi_done 16 cycles after start.
module tb_spi_frame_sequencer;

  localparam logic [55:0] TBL = 56'hFFFFFF_0004F000;  // words 0..6 = 00,F0,04,00,FF,FF,FF
  logic [7:0] exp7 [7] = '{8'h00, 8'hF0, 8'h04, 8'h00, 8'hFF, 8'hFF, 8'hFF};

  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, rst_b = 1'b0;
  logic trig_a = 1'b0, abort_a = 1'b0, stray_e = 1'b0, zero = 1'b0;
  logic rsp_a = 1'b0, rsp_l = 1'b0, rsp_e = 1'b0;
  int   cd_a = 0, cd_l = 0, cd_e = 0;

  logic       start_a, sync_a, done_a;
  logic [7:0] data_a;
  logic [2:0] idx_a;
  logic       start_l, sync_l, done_l;
  logic [7:0] data_l;
  logic [2:0] idx_l;
  logic       start_e, sync_e, done_e;
  logic [7:0] data_e;
  logic [0:0] idx_e;

  spi_frame_sequencer #(.DATA_W(8), .NUM_WORDS(7), .INIT_DATA(TBL), .FRAME_END(7'b1000010),
    .PWR_WAIT(1000), .GAP_CYC(2), .LOOP(1'b0)) u_a (
    .clk(clk), .rst_n(rst_a), .trig(trig_a), .abort(abort_a), .spi_done(rsp_a),
    .start(start_a), .data_out(data_a), .sync(sync_a), .word_idx(idx_a), .seq_done(done_a));

  spi_frame_sequencer #(.DATA_W(8), .NUM_WORDS(7), .INIT_DATA(TBL), .FRAME_END(7'b1000010),
    .PWR_WAIT(20), .GAP_CYC(2), .LOOP(1'b1)) u_l (
    .clk(clk), .rst_n(rst_b), .trig(zero), .abort(zero), .spi_done(rsp_l),
    .start(start_l), .data_out(data_l), .sync(sync_l), .word_idx(idx_l), .seq_done(done_l));

  spi_frame_sequencer #(.DATA_W(8), .NUM_WORDS(1), .INIT_DATA(8'hA5), .FRAME_END(1'b0),
    .PWR_WAIT(0), .GAP_CYC(2), .LOOP(1'b0)) u_e (
    .clk(clk), .rst_n(rst_b), .trig(zero), .abort(zero), .spi_done(rsp_e | stray_e),
    .start(start_e), .data_out(data_e), .sync(sync_e), .word_idx(idx_e), .seq_done(done_e));

  // edge index since reset release: 0 on the first edge with reset high
  int e_a = -1, e_b = -1;
  always @(posedge clk) begin
    e_a <= rst_a ? e_a + 1 : -1;
    e_b <= rst_b ? e_b + 1 : -1;
  end

  // SPI responders: spi_done is sampled 16 edges after the start edge
  always @(negedge clk) begin
    if (!rst_a) begin cd_a <= 0; rsp_a <= 1'b0; end
    else if (start_a) begin cd_a <= 15; rsp_a <= 1'b0; end
    else if (cd_a != 0) begin cd_a <= cd_a - 1; rsp_a <= (cd_a == 1); end
    else rsp_a <= 1'b0;
    if (!rst_b) begin cd_l <= 0; rsp_l <= 1'b0; end
    else if (start_l) begin cd_l <= 15; rsp_l <= 1'b0; end
    else if (cd_l != 0) begin cd_l <= cd_l - 1; rsp_l <= (cd_l == 1); end
    else rsp_l <= 1'b0;
    if (!rst_b) begin cd_e <= 0; rsp_e <= 1'b0; end
    else if (start_e) begin cd_e <= 15; rsp_e <= 1'b0; end
    else if (cd_e != 0) begin cd_e <= cd_e - 1; rsp_e <= (cd_e == 1); end
    else rsp_e <= 1'b0;
  end

  // monitors: words issued on start, and sync-high run lengths between frames
  logic [7:0] log_a[$], log_l[$];
  int gaps_a[$], gaps_l[$];
  int hi_a = 0, hi_l = 0, starts_e = 0;
  logic lo_a = 1'b0, lo_l = 1'b0, done_seen_l = 1'b0;
  always @(negedge clk) begin
    if (!rst_a) begin hi_a <= 0; lo_a <= 1'b0; end
    else begin
      if (start_a) log_a.push_back(data_a);
      if (sync_a) hi_a <= hi_a + 1;
      else begin
        if (lo_a && hi_a != 0) gaps_a.push_back(hi_a);
        hi_a <= 0; lo_a <= 1'b1;
      end
    end
    if (!rst_b) begin hi_l <= 0; lo_l <= 1'b0; starts_e <= 0; end
    else begin
      if (start_l) log_l.push_back(data_l);
      if (done_l) done_seen_l <= 1'b1;
      if (start_e) starts_e <= starts_e + 1;
      if (sync_l) hi_l <= hi_l + 1;
      else begin
        if (lo_l && hi_l != 0) gaps_l.push_back(hi_l);
        hi_l <= 0; lo_l <= 1'b1;
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (sync_a !== 1'b1) begin failures++; $display("FAIL reset_sync got=%b exp=1", sync_a); end
    checks++; if (start_a !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", start_a); end
    checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_seq_done got=%b exp=0", done_a); end
    checks++; if (idx_a !== 3'd0) begin failures++; $display("FAIL reset_word_idx got=%0d exp=0", idx_a); end
    checks++; if (data_e !== 8'hA5) begin failures++; $display("FAIL reset_data_word0 got=%h exp=a5", data_e); end
    checks++; if (sync_l !== 1'b1) begin failures++; $display("FAIL reset_sync_loop got=%b exp=1", sync_l); end
  endtask

  task automatic test_powerup();
    int t, bn, bg;
    bn = log_a.size(); bg = gaps_a.size(); t = -1;
    rst_a = 1'b1;
    for (int i = 0; i < 1100 && t < 0; i++) begin tick(); if (sync_a === 1'b0) t = e_a; end
    checks++; if (t != 1000) begin failures++; $display("FAIL pwr_sync_edge got=%0d exp=1000", t); end
    checks++; if (start_a !== 1'b0) begin failures++; $display("FAIL pwr_cs_setup_start got=%b exp=0", start_a); end
    tick();
    checks++; if (start_a !== 1'b1) begin failures++; $display("FAIL pwr_first_start got=%b exp=1", start_a); end
    for (int i = 0; i < 2000 && done_a !== 1'b1; i++) tick();
    checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL pwr_seq_done got=%b exp=1", done_a); end
    checks++; if (log_a.size() - bn != 7) begin failures++; $display("FAIL pwr_start_count got=%0d exp=7", log_a.size() - bn); end
    for (int k = 0; k < 7; k++)
      if (log_a.size() > bn + k) begin
        checks++; if (log_a[bn+k] !== exp7[k]) begin failures++; $display("FAIL pwr_word%0d got=%h exp=%h", k, log_a[bn+k], exp7[k]); end
      end
    checks++; if (gaps_a.size() - bg != 1) begin failures++; $display("FAIL pwr_gap_count got=%0d exp=1", gaps_a.size() - bg); end
    if (gaps_a.size() > bg) begin
      checks++; if (gaps_a[bg] != 2) begin failures++; $display("FAIL pwr_gap_len got=%0d exp=2", gaps_a[bg]); end
    end
    checks++; if (idx_a !== 3'd0) begin failures++; $display("FAIL pwr_end_idx got=%0d exp=0", idx_a); end
    checks++; if (sync_a !== 1'b1) begin failures++; $display("FAIL pwr_end_sync got=%b exp=1", sync_a); end
  endtask

  task automatic test_retrigger();
    int bn;
    bn = log_a.size();
    trig_a = 1'b1; tick(); trig_a = 1'b0;
    checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL retrig_seq_done got=%b exp=0", done_a); end
    checks++; if (sync_a !== 1'b0) begin failures++; $display("FAIL retrig_sync got=%b exp=0", sync_a); end
    checks++; if (start_a !== 1'b0) begin failures++; $display("FAIL retrig_early_start got=%b exp=0", start_a); end
    tick();
    checks++; if (start_a !== 1'b1) begin failures++; $display("FAIL retrig_start got=%b exp=1", start_a); end
    for (int i = 0; i < 400 && !(start_a === 1'b1 && idx_a == 3'd2); i++) tick();
    tick(); tick();
    trig_a = 1'b1; tick(); trig_a = 1'b0;
    for (int i = 0; i < 2000 && done_a !== 1'b1; i++) tick();
    checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL retrig_seq_done_end got=%b exp=1", done_a); end
    checks++; if (log_a.size() - bn != 7) begin failures++; $display("FAIL retrig_start_count got=%0d exp=7", log_a.size() - bn); end
    for (int k = 0; k < 7; k++)
      if (log_a.size() > bn + k) begin
        checks++; if (log_a[bn+k] !== exp7[k]) begin failures++; $display("FAIL retrig_word%0d got=%h exp=%h", k, log_a[bn+k], exp7[k]); end
      end
  endtask

  task automatic test_abort();
    int bn;
    logic found;
    bn = log_a.size(); found = 1'b0;
    trig_a = 1'b1; tick(); trig_a = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin tick(); if (rsp_a === 1'b1 && idx_a == 3'd3) found = 1'b1; end
    checks++; if (!found) begin failures++; $display("FAIL abort_reach_word3 got=0 exp=1"); end
    abort_a = 1'b1; tick(); abort_a = 1'b0;
    checks++; if (sync_a !== 1'b1) begin failures++; $display("FAIL abort_sync got=%b exp=1", sync_a); end
    checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL abort_seq_done got=%b exp=1", done_a); end
    checks++; if (idx_a !== 3'd0) begin failures++; $display("FAIL abort_word_idx got=%0d exp=0", idx_a); end
    checks++; if (start_a !== 1'b0) begin failures++; $display("FAIL abort_start got=%b exp=0", start_a); end
    repeat (40) tick();
    checks++; if (log_a.size() - bn != 4) begin failures++; $display("FAIL abort_start_count got=%0d exp=4", log_a.size() - bn); end
    abort_a = 1'b1; tick(); abort_a = 1'b0; tick();
    checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL abort_in_done got=%b exp=1", done_a); end
  endtask

  task automatic test_async_reset();
    int t;
    t = -1;
    trig_a = 1'b1; tick(); trig_a = 1'b0;
    for (int i = 0; i < 400 && !(start_a === 1'b1 && idx_a == 3'd1); i++) tick();
    repeat (3) tick();
    checks++; if (sync_a !== 1'b0) begin failures++; $display("FAIL areset_pre_sync got=%b exp=0", sync_a); end
    #2 rst_a = 1'b0; #1;
    checks++; if (sync_a !== 1'b1) begin failures++; $display("FAIL areset_sync got=%b exp=1", sync_a); end
    checks++; if (start_a !== 1'b0) begin failures++; $display("FAIL areset_start got=%b exp=0", start_a); end
    checks++; if (idx_a !== 3'd0) begin failures++; $display("FAIL areset_word_idx got=%0d exp=0", idx_a); end
    repeat (2) tick();
    rst_a = 1'b1;
    for (int i = 0; i < 1100 && t < 0; i++) begin tick(); if (sync_a === 1'b0) t = e_a; end
    checks++; if (t != 1000) begin failures++; $display("FAIL areset_pwr_edge got=%0d exp=1000", t); end
  endtask

  task automatic test_edge_params();
    stray_e = 1'b1; rst_b = 1'b1;
    tick();
    checks++; if (sync_e !== 1'b0) begin failures++; $display("FAIL edge_sync0 got=%b exp=0", sync_e); end
    checks++; if (start_e !== 1'b0) begin failures++; $display("FAIL edge_start0 got=%b exp=0", start_e); end
    tick();
    checks++; if (start_e !== 1'b1 || e_b != 1) begin failures++; $display("FAIL edge_start1 got=%b@%0d exp=1@1", start_e, e_b); end
    checks++; if (data_e !== 8'hA5) begin failures++; $display("FAIL edge_data got=%h exp=a5", data_e); end
    tick(); stray_e = 1'b0;
    for (int i = 0; i < 200 && done_e !== 1'b1; i++) tick();
    checks++; if (done_e !== 1'b1) begin failures++; $display("FAIL edge_seq_done got=%b exp=1", done_e); end
    checks++; if (idx_e !== 1'b0) begin failures++; $display("FAIL edge_word_idx got=%0d exp=0", idx_e); end
    stray_e = 1'b1; tick(); stray_e = 1'b0; repeat (3) tick();
    checks++; if (starts_e != 1) begin failures++; $display("FAIL edge_start_count got=%0d exp=1", starts_e); end
    checks++; if (done_e !== 1'b1) begin failures++; $display("FAIL edge_stray_done got=%b exp=1", done_e); end
  endtask

  task automatic test_loop();
    for (int i = 0; i < 3000 && log_l.size() < 21; i++) tick();
    checks++; if (log_l.size() < 21) begin failures++; $display("FAIL loop_start_count got=%0d exp>=21", log_l.size()); end
    for (int k = 0; k < 21; k++)
      if (log_l.size() > k) begin
        checks++; if (log_l[k] !== exp7[k%7]) begin failures++; $display("FAIL loop_word%0d got=%h exp=%h", k, log_l[k], exp7[k%7]); end
      end
    checks++; if (gaps_l.size() < 5) begin failures++; $display("FAIL loop_gap_count got=%0d exp>=5", gaps_l.size()); end
    for (int k = 0; k < 5; k++)
      if (gaps_l.size() > k) begin
        checks++; if (gaps_l[k] != 2) begin failures++; $display("FAIL loop_gap%0d got=%0d exp=2", k, gaps_l[k]); end
      end
    checks++; if (done_seen_l !== 1'b0) begin failures++; $display("FAIL loop_seq_done got=%b exp=0", done_seen_l); end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_retrigger();
    test_abort();
    test_async_reset();
    test_edge_params();
    test_loop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
